// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array buffer path: buffer geometry and the
// state encoding of the buffer read engine.
package systolic_pkg;

  localparam int BUF_ADR_W = 10;
  localparam int BUF_DAT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } rd_state_e;

endpackage

// File: rtl/buf_skid_fifo2.sv
// Two-entry register FIFO; the head entry is presented directly from a register
// so the stream output stays stable until popped.
module buf_skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] entry_q [2];
  logic         wr_idx_q;
  logic         rd_idx_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        entry_q[wr_idx_q] <= push_data_i;
        wr_idx_q          <= ~wr_idx_q;
      end
      if (pop_ok) rd_idx_q <= ~rd_idx_q;
      cnt_q <= cnt_d;
    end
  end

  assign head_data_o = entry_q[rd_idx_q];
  assign full_o      = (cnt_q == 2'd2);
  assign empty_o     = (cnt_q == 2'd0);
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/buf_stream_reader.sv
// Buffer RAM read engine: sweeps LEN words from BASE (address wraps), hides the
// RAM's one-cycle read latency and emits the words as a valid/ready stream.
module buf_stream_reader
  import systolic_pkg::*;
#(
  parameter int ADR_W = BUF_ADR_W,
  parameter int DAT_W = BUF_DAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W:0]   length,
  output logic             busy,
  output logic             done,
  output logic [ADR_W-1:0] ram_radr,
  input  logic [DAT_W-1:0] ram_rdata,
  output logic             out_valid,
  output logic [DAT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int CW = ADR_W + 1;

  rd_state_e        state_q, state_d;
  logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    remain_q, remain_d;
  logic [ADR_W-1:0] radr_hold_q;
  logic             inflight_q;
  logic             inflight_last_q;

  logic [DAT_W:0]   head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_cnt;
  logic             pop;
  logic [2:0]       occ;
  logic             credit_ok;
  logic             issue;
  logic             last_issue;
  logic             drain_empty;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign occ       = 3'(fifo_cnt) + 3'(inflight_q);

  // Two slots of credit: FIFO words plus the read in flight, minus what leaves now.
  // When full, only a pop with nothing in flight frees a slot.
  assign credit_ok = fifo_full ? (pop && !inflight_q)
                               : ((occ < 3'd2) || pop);

  assign issue       = (state_q == S_RUN) && (remain_q != '0) && credit_ok;
  assign last_issue  = issue && (remain_q == CW'(1));
  assign drain_empty = !inflight_q &&
                       ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d = base_adr;
          remain_d = length;
          state_d  = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the final word is accepted so done follows it by one cycle.
        if (drain_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rd_ptr_q        <= '0;
      remain_q        <= '0;
      radr_hold_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      remain_q        <= remain_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if (issue) radr_hold_q <= rd_ptr_q;
    end
  end

  assign ram_radr = issue ? rd_ptr_q : radr_hold_q;

  buf_skid_fifo2 #(.W(DAT_W + 1)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, ram_rdata}),
    .pop_i       (pop),
    .head_data_o (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .cnt_o       (fifo_cnt)
  );

  assign out_data = head[DAT_W-1:0];
  assign out_last = head[DAT_W] && out_valid;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_buf_stream_reader.sv
// Bench for buf_stream_reader: a behavioural RAM plus an expected-stream model
// built directly from memory contents, base and length.
module tb_buf_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_adr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;

  logic [DW-1:0] mem [DEPTH];

  buf_stream_reader #(.ADR_W(AW), .DAT_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_radr  (ram_radr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // RAM registers the address; data appears the following cycle.
  always @(posedge clk) ram_rdata <= mem[ram_radr];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int done_cnt, valid_cnt, stab_err;
  bit stall_q;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [DW-1:0] rx_data[$];
  logic          rx_last[$];
  logic [AW-1:0] ram_log[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];

  task automatic clear_mon();
    rx_data.delete(); rx_last.delete(); ram_log.delete();
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    done_cnt = 0; valid_cnt = 0; stab_err = 0; stall_q = 1'b0;
  endtask

  task automatic sample();
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      if (out_last) last_hs_cyc = cyc;
    end
    if (stall_q && (!out_valid || out_data !== stall_data || out_last !== stall_last))
      stab_err++;
    stall_q    = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    if (out_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) ram_log.push_back(ram_radr);
  endtask

  task automatic step(input bit rnd, input bit st, input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    cyc++;
    start = st;
    if (st) begin
      base_adr = b;
      length   = l;
    end
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    sample();
  endtask

  task automatic build_exp(input logic [AW-1:0] b, input int l);
    exp_data.delete(); exp_last.delete();
    for (int i = 0; i < l; i++) begin
      exp_data.push_back(mem[(int'(b) + i) % DEPTH]);
      exp_last.push_back(i == l - 1);
    end
  endtask

  task automatic run_sweep(input logic [AW-1:0] b, input int l, input bit rnd, input int maxc);
    clear_mon();
    build_exp(b, l);
    step(rnd, 1'b1, b, (AW+1)'(l));
    start_cyc = cyc;
    for (int i = 0; i < maxc; i++) begin
      step(rnd, 1'b0, '0, '0);
      if (done) break;
    end
    n_tests++;
    if (!done) begin
      $display("FAIL sweep_timeout: base=%h len=%0d no done within %0d cycles", b, l, maxc);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_adr = '0; length = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0)      begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
    n_tests++; if (done !== 1'b0)      begin $display("FAIL reset_done: got %b want 0", done); n_fail++; end
    n_tests++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", out_valid); n_fail++; end
    n_tests++; if (out_last !== 1'b0)  begin $display("FAIL reset_last: got %b want 0", out_last); n_fail++; end
    n_tests++; if (out_data !== '0)    begin $display("FAIL reset_data: got %h want 0", out_data); n_fail++; end
    n_tests++; if (ram_radr !== '0)    begin $display("FAIL reset_radr: got %h want 0", ram_radr); n_fail++; end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int errs = 0;
    run_sweep(10'h010, 4, 1'b0, 40);
    for (int i = 0; i < 4; i++)
      if (i >= ram_log.size() || ram_log[i] !== AW'(10'h010 + i)) errs++;
    n_tests++; if (errs != 0) begin $display("FAIL basic_radr: %0d wrong issue addresses, want 0", errs); n_fail++; end
    n_tests++; if (first_valid_cyc - start_cyc != 3) begin
      $display("FAIL basic_latency: first valid %0d cycles after start, want 3", first_valid_cyc - start_cyc); n_fail++; end
    n_tests++; if (done_cyc - last_hs_cyc != 1) begin
      $display("FAIL basic_done_gap: done %0d cycles after last handshake, want 1", done_cyc - last_hs_cyc); n_fail++; end
    n_tests++; if (busy !== 1'b0 || done_cnt != 1) begin
      $display("FAIL basic_busy_done: busy=%b done_pulses=%0d want 0/1", busy, done_cnt); n_fail++; end
    errs = 0;
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 4) begin
      $display("FAIL basic_stream: %0d bad of %0d received, want 0 bad of 4", errs, rx_data.size()); n_fail++; end
    $display("[TB] basic sweep base=010 len=4 words=%0d", rx_data.size());
  endtask

  task automatic test_wrap();
    int errs = 0;
    run_sweep(10'h3FE, 4, 1'b0, 40);
    for (int i = 0; i < 4; i++)
      if (i >= ram_log.size() || ram_log[i] !== AW'((10'h3FE + i) % DEPTH)) errs++;
    n_tests++; if (errs != 0) begin $display("FAIL wrap_radr: %0d wrong issue addresses, want 0", errs); n_fail++; end
    errs = 0;
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 4) begin
      $display("FAIL wrap_stream: %0d bad of %0d received, want 0 bad of 4", errs, rx_data.size()); n_fail++; end
    n_tests++; if (rx_data.size() != 4 || rx_data[3] !== mem[1] || rx_last[3] !== 1'b1) begin
      $display("FAIL wrap_last: final word not mem[001] with last, got %0d words", rx_data.size()); n_fail++; end
    $display("[TB] wrap sweep base=3FE len=4 words=%0d", rx_data.size());
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] uniq[$];
    int errs = 0;
    run_sweep(10'h2F8, 16, 1'b1, 400);
    foreach (ram_log[i]) if (uniq.size() == 0 || uniq[$] !== ram_log[i]) uniq.push_back(ram_log[i]);
    for (int i = 0; i < 16; i++) if (i >= uniq.size() || uniq[i] !== AW'(10'h2F8 + i)) errs++;
    n_tests++; if (errs != 0 || uniq.size() != 16) begin
      $display("FAIL bp_issue: %0d distinct addresses, %0d wrong, want 16/0", uniq.size(), errs); n_fail++; end
    errs = 0;
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 16) begin
      $display("FAIL bp_stream: %0d bad of %0d received, want 0 bad of 16", errs, rx_data.size()); n_fail++; end
    n_tests++; if (stab_err != 0) begin
      $display("FAIL bp_stable: %0d stall cycles changed the word, want 0", stab_err); n_fail++; end
    $display("[TB] backpressure sweep len=16 words=%0d", rx_data.size());
  endtask

  task automatic test_length_edges();
    logic [AW-1:0] radr_before;
    int errs = 0;
    radr_before = ram_radr;
    run_sweep(10'h123, 0, 1'b0, 20);
    n_tests++; if (done_cyc - start_cyc != 1) begin
      $display("FAIL len0_done: done %0d cycles after start, want 1", done_cyc - start_cyc); n_fail++; end
    n_tests++; if (valid_cnt != 0 || ram_log.size() != 0 || ram_radr !== radr_before) begin
      $display("FAIL len0_quiet: valid_cycles=%0d busy_cycles=%0d radr=%h want 0/0/%h",
               valid_cnt, ram_log.size(), ram_radr, radr_before); n_fail++; end
    $display("[TB] len=0 sweep done after %0d cycles", done_cyc - start_cyc);
    run_sweep(10'h200, 1024, 1'b0, 1100);
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 1024) begin
      $display("FAIL full_stream: %0d bad of %0d received, want 0 bad of 1024", errs, rx_data.size()); n_fail++; end
    n_tests++; if (rx_data.size() != 1024 || rx_data[1023] !== mem[10'h1FF] || rx_last[1023] !== 1'b1) begin
      $display("FAIL full_last: final word not mem[1FF] with last, got %0d words", rx_data.size()); n_fail++; end
    $display("[TB] full-buffer sweep base=200 words=%0d", rx_data.size());
  endtask

  task automatic test_start_while_busy();
    logic [AW-1:0] uniq[$];
    int errs = 0;
    clear_mon();
    build_exp(10'h100, 8);
    step(1'b1, 1'b1, 10'h100, 11'd8);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, (i == 2), 10'h300, 11'd5);
      if (done) break;
    end
    foreach (ram_log[i]) if (uniq.size() == 0 || uniq[$] !== ram_log[i]) uniq.push_back(ram_log[i]);
    for (int i = 0; i < 8; i++) if (i >= uniq.size() || uniq[i] !== AW'(10'h100 + i)) errs++;
    n_tests++; if (errs != 0 || uniq.size() != 8) begin
      $display("FAIL restart_issue: %0d distinct addresses, %0d wrong, want 8/0", uniq.size(), errs); n_fail++; end
    errs = 0;
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 8 || done_cnt != 1) begin
      $display("FAIL restart_stream: %0d bad of %0d received, done_pulses=%0d want 0/8/1",
               errs, rx_data.size(), done_cnt); n_fail++; end
    $display("[TB] start-while-busy sweep words=%0d", rx_data.size());
  endtask

  task automatic test_mid_reset();
    int errs = 0;
    clear_mon();
    step(1'b0, 1'b1, 10'h0A0, 11'd10);
    for (int i = 0; i < 50 && rx_data.size() < 5; i++) step(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1 rst = 1'b1; cyc++;
    @(posedge clk); #1 rst = 1'b0; cyc++;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rst_mid: valid=%b busy=%b done=%b want 0/0/0", out_valid, busy, done); n_fail++; end
    clear_mon();
    repeat (5) step(1'b0, 1'b0, '0, '0);
    n_tests++; if (done_cnt != 0 || valid_cnt != 0) begin
      $display("FAIL rst_quiet: done_pulses=%0d valid_cycles=%0d want 0/0", done_cnt, valid_cnt); n_fail++; end
    run_sweep(10'h050, 2, 1'b0, 30);
    foreach (exp_data[i]) if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) errs++;
    n_tests++; if (errs != 0 || rx_data.size() != 2) begin
      $display("FAIL rst_fresh: %0d bad of %0d received, want 0 bad of 2", errs, rx_data.size()); n_fail++; end
    $display("[TB] mid-sweep reset then len=2 sweep words=%0d", rx_data.size());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_length_edges();
    test_start_while_busy();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
